servant_wb_arbiter: RTL and testbench
=====================================

// Module: servant_wb_arbiter
// PURPOSE
// - Two-master, one-slave Wishbone-classic arbiter sharing the servant RAM port between the SERV core
//   (master 0) and a firmware loader/debug master (master 1).
// - Round-robin grant, transaction lock until ack, bus-timeout watchdog returning err to a stalled master.
// - Sits between the core/loader buses and the RAM instance inside the service top level.
// PARAMETERS
// - AW       13  address width in bytes, $clog2(memsize) for memsize=8192
// - TIMEOUT  32  cycles a granted transfer may wait for i_s_ack before err; legal range 2..255
// PORTS
// - wb_clk    in   1   clock; all logic on posedge
// - wb_rst_n  in   1   reset, synchronous, active-low
// - i_m0_adr  in   AW  master 0 byte address (likewise i_m1_adr)
// - i_m0_dat  in   32  master 0 write data (likewise i_m1_dat)
// - i_m0_sel  in   4   master 0 byte enables (likewise i_m1_sel)
// - i_m0_we   in   1   master 0 write enable (likewise i_m1_we)
// - i_m0_cyc  in   1   master 0 request, held until ack/err (likewise i_m1_cyc)
// - o_m0_rdt  out  32  read data to master 0 (likewise o_m1_rdt)
// - o_m0_ack  out  1   transfer done, 1 cycle (likewise o_m1_ack)
// - o_m0_err  out  1   timeout, 1 cycle (likewise o_m1_err)
// - o_s_adr/o_s_dat/o_s_sel/o_s_we/o_s_cyc  out  AW/32/4/1/1  muxed slave request
// - i_s_rdt   in   32  slave read data
// - i_s_ack   in   1   slave ack
// BEHAVIOUR
// - Reset (wb_rst_n=0 at posedge): state=IDLE, last=1 (master 0 wins first tie), timer=0;
//   all o_*_ack/err=0, o_s_cyc=0. Reset mid-transfer aborts it silently, no ack/err issued.
// - FSM states IDLE, BUSY0, BUSY1, RECOVER.
// - IDLE: one requester -> BUSYn. Both -> master != last. None -> stay. Grant is registered;
//   o_s_cyc rises the cycle after request is first seen (1-cycle arbitration latency).
// - BUSYn: o_s_* = master n's inputs, o_s_cyc = i_mn_cyc. Other master's inputs ignored.
//   - i_s_ack=1: o_mn_ack=i_s_ack combinationally; o_mn_rdt=i_s_rdt; last<=n; -> RECOVER.
//   - i_mn_cyc drops without ack (abort): -> IDLE next cycle, last<=n, no ack/err.
//   - timer==TIMEOUT-1 and no ack: o_mn_err=1 for that cycle; last<=n; -> RECOVER.
//   - ack and timeout in the same cycle: ack wins, err stays 0.
// - RECOVER: o_s_cyc=0 for exactly one cycle (SERV drops cyc after ack); -> IDLE.
//   A request pending during RECOVER is arbitrated in IDLE next cycle.
// - timer: 8-bit, cleared on entering BUSYn, increments each BUSY cycle, saturates; no wrap.
// - o_mn_rdt: i_s_rdt when granted to n, else 0. Non-granted ack/err are always 0.
// - Steady back-to-back contention: grants alternate 0,1,0,1; each transfer occupies
//   IDLE+BUSY(>=1)+RECOVER, so neither master starves.
// - o_s_adr/dat/sel/we are 0 when o_s_cyc=0.
// STRUCTURE
// - Shared package servant_pkg: FSM state enum (2 bits), WB_DW=32, WB_SELW=4.
// - One sub-module servant_wb_timer (clear/enable/saturate counter, expiry flag);
//   the grant FSM and datapath muxes stay in this module.
// TESTING
// - Reset: wb_rst_n=0 for 3 cycles with both cyc=1 -> o_s_cyc=0, all ack/err=0; after release m0 granted first.
// - Single read: m0 cyc, adr=0x010, slave acks on 2nd BUSY cycle with 0xDEADBEEF ->
//   o_m0_ack 1 cycle, o_m0_rdt=0xDEADBEEF, then 1 cycle o_s_cyc=0.
// - Contention: both cyc held, slave acks immediately -> grant order 0,1,0,1 over 4 transfers.
// - Timeout: m1 write, slave never acks -> o_m1_err=1 exactly at cycle TIMEOUT(32) of BUSY1, no ack.
// - Ack on expiry cycle: slave acks at BUSY cycle 32 -> o_m0_ack=1, o_m0_err=0.
// - Abort/reset mid-op: m0 drops cyc in BUSY0 -> IDLE next cycle, m1 granted; repeat with reset -> IDLE, no ack/err.

Source files
------------

// File: rtl/servant_pkg.sv
// Shared types and widths for the servant Wishbone arbiter slice.
// Latency: none; this package holds only types and constants.
// Backpressure: none; this package holds only types and constants.
package servant_pkg;

    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY0   = 2'd1,
        ST_BUSY1   = 2'd2,
        ST_RECOVER = 2'd3
    } arb_state_e;

endpackage

// File: rtl/servant_wb_arbiter_if.sv
// Wishbone-classic bus bundle: request from master, response from slave.
// Latency: wires only.
// Backpressure: cyc is held by the master until ack or err returns.
interface servant_wb_arbiter_if #(
    parameter int AW = 13
);
    import servant_pkg::*;

    logic [AW-1:0]      adr;
    logic [WB_DW-1:0]   dat;
    logic [WB_SELW-1:0] sel;
    logic               we;
    logic               cyc;
    logic [WB_DW-1:0]   rdt;
    logic               ack;
    logic               err;

    modport master (output adr, dat, sel, we, cyc, input rdt, ack, err);
    modport slave  (input adr, dat, sel, we, cyc, output rdt, ack, err);
    // RAM side has no error path; only the arbiter itself generates err.
    modport ram_master (output adr, dat, sel, we, cyc, input rdt, ack);

endinterface

// File: rtl/servant_wb_timer.sv
// Bus watchdog: counts cycles of a granted transfer, flags the expiry cycle.
// Latency: expired is combinational from the registered count.
// Backpressure: none; saturates at 255 instead of wrapping.
module servant_wb_timer #(
    parameter int TIMEOUT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: clear wins, otherwise count up and stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 8'd0;
        end else if (en && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/servant_wb_arbiter.sv
// Two-master round-robin Wishbone-classic arbiter in front of the servant RAM.
// Latency: 1 cycle to grant; ack/err/rdt pass through combinationally once granted.
// Backpressure: the loser waits with cyc held; a stalled slave is cut off with err.
module servant_wb_arbiter
    import servant_pkg::*;
#(
    parameter int AW      = 13,
    parameter int TIMEOUT = 32
) (
    input  logic                    wb_clk,
    input  logic                    wb_rst_n,
    servant_wb_arbiter_if.slave      m0,
    servant_wb_arbiter_if.slave      m1,
    servant_wb_arbiter_if.ram_master s
);
    arb_state_e         state_q;
    arb_state_e         state_d;
    logic               last_q;
    logic               last_d;
    logic               busy;
    logic               gnt1;
    logic               expired;
    logic [AW-1:0]      adr_mux;
    logic [WB_DW-1:0]   dat_mux;
    logic [WB_SELW-1:0] sel_mux;
    logic               we_mux;
    logic               req_mux;
    logic               cyc_out;

    assign busy = (state_q == ST_BUSY0) || (state_q == ST_BUSY1);
    assign gnt1 = (state_q == ST_BUSY1);

    // Timer restarts whenever the bus is not owned, so it reads 0 on the first BUSY cycle.
    servant_wb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (wb_clk),
        .rst_n   (wb_rst_n),
        .clr     (!busy),
        .en      (busy),
        .expired (expired)
    );

    // Pick the request of whichever master currently owns the bus.
    always_comb begin
        adr_mux = m0.adr;
        dat_mux = m0.dat;
        sel_mux = m0.sel;
        we_mux  = m0.we;
        req_mux = m0.cyc;
        if (gnt1) begin
            adr_mux = m1.adr;
            dat_mux = m1.dat;
            sel_mux = m1.sel;
            we_mux  = m1.we;
            req_mux = m1.cyc;
        end
    end

    // A reset cycle suppresses the bus so an in-flight transfer dies silently.
    assign cyc_out = wb_rst_n && busy && req_mux;

    assign s.cyc = cyc_out;
    assign s.adr = cyc_out ? adr_mux : '0;
    assign s.dat = cyc_out ? dat_mux : '0;
    assign s.sel = cyc_out ? sel_mux : '0;
    assign s.we  = cyc_out && we_mux;

    // Responses only reach the owner; ack beats a coincident timeout.
    assign m0.ack = cyc_out && !gnt1 && s.ack;
    assign m1.ack = cyc_out &&  gnt1 && s.ack;
    assign m0.err = cyc_out && !gnt1 && !s.ack && expired;
    assign m1.err = cyc_out &&  gnt1 && !s.ack && expired;
    assign m0.rdt = (state_q == ST_BUSY0) ? s.rdt : '0;
    assign m1.rdt = gnt1 ? s.rdt : '0;

    // Grant decision and transfer completion tracking.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    state_d = last_q ? ST_BUSY0 : ST_BUSY1;
                end else if (m0.cyc) begin
                    state_d = ST_BUSY0;
                end else if (m1.cyc) begin
                    state_d = ST_BUSY1;
                end
            end
            ST_BUSY0, ST_BUSY1: begin
                if (!req_mux) begin
                    state_d = ST_IDLE;
                    last_d  = gnt1;
                end else if (s.ack || expired) begin
                    state_d = ST_RECOVER;
                    last_d  = gnt1;
                end
            end
            ST_RECOVER: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; after reset master 0 wins the first tie.
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_servant_wb_arbiter.sv
module tb_servant_wb_arbiter;
    import servant_pkg::*;

    localparam int AW      = 13;
    localparam int TIMEOUT = 32;

    logic wb_clk   = 1'b0;
    logic wb_rst_n = 1'b0;
    always #5 wb_clk = ~wb_clk;

    servant_wb_arbiter_if #(.AW(AW)) m0_bus ();
    servant_wb_arbiter_if #(.AW(AW)) m1_bus ();
    servant_wb_arbiter_if #(.AW(AW)) s_bus ();

    servant_wb_arbiter #(
        .AW      (AW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .m0       (m0_bus),
        .m1       (m1_bus),
        .s        (s_bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Master-side stimulus state, copied onto the two buses by push_m.
    logic          cyc_r [2];
    logic [AW-1:0] adr_r [2];
    logic [31:0]   dat_r [2];
    logic [3:0]    sel_r [2];
    logic          we_r  [2];

    typedef struct {
        logic        rst_n;
        logic        c0;
        logic        c1;
        logic        sack;
        logic [31:0] srdt;
        logic        ecyc;
        logic [31:0] eadr;
        logic        eack0;
        logic        eack1;
        logic        eerr0;
        logic        eerr1;
        logic [31:0] erdt0;
        logic [31:0] erdt1;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge wb_clk);
        #1;
    endtask

    task automatic sample;
        @(negedge wb_clk);
    endtask

    task automatic push_m;
        m0_bus.cyc = cyc_r[0]; m0_bus.adr = adr_r[0]; m0_bus.dat = dat_r[0];
        m0_bus.sel = sel_r[0]; m0_bus.we  = we_r[0];
        m1_bus.cyc = cyc_r[1]; m1_bus.adr = adr_r[1]; m1_bus.dat = dat_r[1];
        m1_bus.sel = sel_r[1]; m1_bus.we  = we_r[1];
    endtask

    // Reference model state: owner of the bus (-1 none), cool-down flag,
    // cycles already spent waiting on the slave, and last master served.
    int who;
    bit cooling;
    int waited;
    int prev;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int order [$];
        int busy_cnt;
        int err_at;
        logic saw_ack, saw_err0, got_ack, got_err;
        logic done [2];
        logic stall, prev_scyc;
        logic e_scyc;
        logic [31:0] e_adr, e_dat;
        logic e_we;
        logic e_ack [2];
        logic e_err [2];
        logic [31:0] e_rdt [2];

        s_bus.err = 1'b0;
        s_bus.ack = 1'b0;
        s_bus.rdt = '0;
        for (int n = 0; n < 2; n++) begin
            cyc_r[n] = 1'b0; dat_r[n] = 32'h0; sel_r[n] = 4'hF; we_r[n] = 1'b0;
        end
        adr_r[0] = 13'h010;
        adr_r[1] = 13'h020;

        // ---- table: reset with both requesting, single read, hand-over to m1 ----
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 32'h010, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hAAAA5555, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hAAAA5555, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h12345678, 1'b1, 32'h020, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h12345678};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};

        for (int i = 0; i < 11; i++) begin
            wb_rst_n  = tbl[i].rst_n;
            cyc_r[0]  = tbl[i].c0;
            cyc_r[1]  = tbl[i].c1;
            push_m();
            s_bus.ack = tbl[i].sack;
            s_bus.rdt = tbl[i].srdt;
            sample();
            chk($sformatf("tbl%0d_s_cyc", i), s_bus.cyc,  tbl[i].ecyc);
            chk($sformatf("tbl%0d_s_adr", i), s_bus.adr,  tbl[i].eadr);
            chk($sformatf("tbl%0d_ack0", i),  m0_bus.ack, tbl[i].eack0);
            chk($sformatf("tbl%0d_ack1", i),  m1_bus.ack, tbl[i].eack1);
            chk($sformatf("tbl%0d_err0", i),  m0_bus.err, tbl[i].eerr0);
            chk($sformatf("tbl%0d_err1", i),  m1_bus.err, tbl[i].eerr1);
            chk($sformatf("tbl%0d_rdt0", i),  m0_bus.rdt, tbl[i].erdt0);
            chk($sformatf("tbl%0d_rdt1", i),  m1_bus.rdt, tbl[i].erdt1);
            tick();
        end
        s_bus.ack = 1'b0;
        s_bus.rdt = '0;

        // ---- contention: both hold cyc, slave acks at once; m1 was served last ----
        adr_r[0] = 13'h100; adr_r[1] = 13'h200;
        cyc_r[0] = 1'b1;    cyc_r[1] = 1'b1;
        push_m();
        for (int i = 0; i < 40; i++) begin
            sample();
            if (m0_bus.ack) order.push_back(0);
            if (m1_bus.ack) order.push_back(1);
            if (order.size() == 4) break;
            tick();
            s_bus.ack = s_bus.cyc;
        end
        chk("contend_count", order.size(), 4);
        for (int k = 0; k < order.size(); k++)
            chk($sformatf("contend_grant%0d", k), order[k], k % 2);
        tick();
        cyc_r[0] = 1'b0; cyc_r[1] = 1'b0; push_m();
        s_bus.ack = 1'b0;
        tick(); tick();

        // ---- timeout: m1 write, slave never acks ----
        adr_r[1] = 13'h044; dat_r[1] = 32'hCAFEF00D; sel_r[1] = 4'b0011; we_r[1] = 1'b1;
        cyc_r[1] = 1'b1; push_m();
        busy_cnt = 0; err_at = -1; saw_ack = 1'b0; saw_err0 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            sample();
            if (s_bus.cyc) begin
                busy_cnt++;
                if (busy_cnt == 1) begin
                    chk("timeout_s_we",  s_bus.we,  1'b1);
                    chk("timeout_s_dat", s_bus.dat, 32'hCAFEF00D);
                    chk("timeout_s_sel", s_bus.sel, 4'b0011);
                end
            end
            if (m1_bus.ack || m0_bus.ack) saw_ack = 1'b1;
            if (m0_bus.err) saw_err0 = 1'b1;
            if (m1_bus.err) begin
                err_at = busy_cnt;
                break;
            end
            tick();
        end
        chk("timeout_err_cycle", err_at, TIMEOUT);
        chk("timeout_no_ack", saw_ack, 1'b0);
        chk("timeout_no_err0", saw_err0, 1'b0);
        tick();
        cyc_r[1] = 1'b0; we_r[1] = 1'b0; push_m();
        sample();
        chk("timeout_recover_cyc", s_bus.cyc, 1'b0);
        tick(); tick();

        // ---- ack lands on the expiry cycle: ack wins ----
        adr_r[0] = 13'h080; cyc_r[0] = 1'b1; push_m();
        s_bus.ack = 1'b0; s_bus.rdt = 32'h0BADF00D;
        busy_cnt = 0; got_ack = 1'b0; got_err = 1'b0;
        for (int i = 0; i < 60; i++) begin
            sample();
            if (s_bus.cyc) busy_cnt++;
            if (m0_bus.ack || m0_bus.err) begin
                got_ack = m0_bus.ack;
                got_err = m0_bus.err;
                chk("expiry_rdt", m0_bus.rdt, 32'h0BADF00D);
                break;
            end
            tick();
            s_bus.ack = s_bus.cyc && (busy_cnt == TIMEOUT - 1);
        end
        chk("expiry_cycle", busy_cnt, TIMEOUT);
        chk("expiry_ack", got_ack, 1'b1);
        chk("expiry_err", got_err, 1'b0);
        tick();
        cyc_r[0] = 1'b0; push_m(); s_bus.ack = 1'b0;
        tick(); tick();

        // ---- abort: m0 drops cyc mid-transfer, m1 then granted ----
        adr_r[0] = 13'h0A0; adr_r[1] = 13'h0B0;
        cyc_r[0] = 1'b1; push_m();
        tick();
        sample();
        chk("abort_busy0_cyc", s_bus.cyc, 1'b1);
        chk("abort_busy0_adr", s_bus.adr, 32'h0A0);
        tick();
        cyc_r[0] = 1'b0; cyc_r[1] = 1'b1; push_m();
        sample();
        chk("abort_drop_cyc",  s_bus.cyc,  1'b0);
        chk("abort_drop_ack",  m0_bus.ack, 1'b0);
        chk("abort_drop_err",  m0_bus.err, 1'b0);
        tick();
        sample();
        chk("abort_idle_cyc", s_bus.cyc, 1'b0);
        tick();
        sample();
        chk("abort_m1_cyc", s_bus.cyc, 1'b1);
        chk("abort_m1_adr", s_bus.adr, 32'h0B0);

        // ---- reset while m1 owns the bus and slave acks ----
        tick();
        wb_rst_n = 1'b0; s_bus.ack = 1'b1;
        sample();
        chk("rstmid_ack1", m1_bus.ack, 1'b0);
        chk("rstmid_err1", m1_bus.err, 1'b0);
        tick();
        wb_rst_n = 1'b1; s_bus.ack = 1'b0;
        sample();
        chk("rstmid_idle_cyc", s_bus.cyc, 1'b0);
        chk("rstmid_idle_ack", m1_bus.ack, 1'b0);
        tick();
        cyc_r[1] = 1'b0; push_m();
        tick(); tick();

        // ---- randomized traffic against the reference model ----
        wb_rst_n = 1'b0;
        tick(); tick();
        wb_rst_n = 1'b1;
        who = -1; cooling = 1'b0; waited = 0; prev = 1;
        done[0] = 1'b0; done[1] = 1'b0;
        prev_scyc = 1'b0; stall = 1'b0;
        for (int cyc_i = 0; cyc_i < 2000; cyc_i++) begin
            wb_rst_n = ($urandom_range(0, 299) != 0);
            for (int n = 0; n < 2; n++) begin
                if (cyc_r[n] && done[n]) begin
                    cyc_r[n] = 1'b0;
                end else if (cyc_r[n] && ($urandom_range(0, 63) == 0)) begin
                    cyc_r[n] = 1'b0;
                end else if (!cyc_r[n] && ($urandom_range(0, 2) == 0)) begin
                    cyc_r[n] = 1'b1;
                    adr_r[n] = AW'($urandom);
                    dat_r[n] = $urandom;
                    sel_r[n] = 4'($urandom);
                    we_r[n]  = 1'($urandom);
                end
            end
            push_m();
            #1;
            if (s_bus.cyc && !prev_scyc) stall = ($urandom_range(0, 9) == 0);
            prev_scyc = s_bus.cyc;
            s_bus.ack = s_bus.cyc && !stall && ($urandom_range(0, 2) == 0);
            s_bus.rdt = $urandom;

            // Expected outputs from the model's view of who owns the bus.
            e_scyc = wb_rst_n && (who >= 0) && !cooling && cyc_r[(who >= 0) ? who : 0];
            e_adr  = e_scyc ? 32'(adr_r[who]) : 32'h0;
            e_dat  = e_scyc ? dat_r[who] : 32'h0;
            e_we   = e_scyc && we_r[who];
            for (int n = 0; n < 2; n++) begin
                e_ack[n] = e_scyc && (who == n) && s_bus.ack;
                e_err[n] = e_scyc && (who == n) && !s_bus.ack && (waited == TIMEOUT - 1);
                e_rdt[n] = (who == n && !cooling) ? s_bus.rdt : 32'h0;
            end

            sample();
            chk("rnd_s_cyc", s_bus.cyc, e_scyc);
            chk("rnd_s_adr", s_bus.adr, e_adr);
            chk("rnd_s_dat", s_bus.dat, e_dat);
            chk("rnd_s_we",  s_bus.we,  e_we);
            chk("rnd_ack0",  m0_bus.ack, e_ack[0]);
            chk("rnd_ack1",  m1_bus.ack, e_ack[1]);
            chk("rnd_err0",  m0_bus.err, e_err[0]);
            chk("rnd_err1",  m1_bus.err, e_err[1]);
            chk("rnd_rdt0",  m0_bus.rdt, e_rdt[0]);
            chk("rnd_rdt1",  m1_bus.rdt, e_rdt[1]);
            done[0] = m0_bus.ack || m0_bus.err;
            done[1] = m1_bus.ack || m1_bus.err;

            // Advance the model one clock.
            if (!wb_rst_n) begin
                who = -1; cooling = 1'b0; waited = 0; prev = 1;
            end else if (cooling) begin
                cooling = 1'b0;
                who = -1;
            end else if (who < 0) begin
                waited = 0;
                if (cyc_r[0] && cyc_r[1]) who = 1 - prev;
                else if (cyc_r[0])        who = 0;
                else if (cyc_r[1])        who = 1;
            end else if (!cyc_r[who]) begin
                prev = who; who = -1;
            end else if (s_bus.ack || (waited == TIMEOUT - 1)) begin
                prev = who; cooling = 1'b1;
            end else begin
                waited++;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
